// File: rtl/bridge_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_fifo_pkg
// Description : Shared constants and sizing helpers for the bridge FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_fifo_pkg;

    localparam int c_def_dsize     = 32;
    localparam int c_def_awidth    = 32;
    localparam int c_def_asize     = 4;
    localparam int c_def_aempty_th = 2;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic int entry_width(input int awidth, input int dsize);
        return awidth + dsize;
    endfunction

endpackage : bridge_fifo_pkg
`default_nettype wire

// File: rtl/bridge_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : bridge_fifo_ram
// Description : Simple dual-port synchronous RAM with a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_fifo_ram #(
    parameter int WIDTH = 64,
    parameter int ABITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [ABITS-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wentry,
    input  logic             i_re,
    input  logic [ABITS-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rentry
);

    logic [WIDTH-1:0] r_mem [0:(2**ABITS)-1];
    logic [WIDTH-1:0] r_rentry;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wentry;
        end
    end

    // Read-before-write: a same-address read returns the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rentry <= '0;
        end else if (i_re) begin
            r_rentry <= r_mem[i_raddr];
        end
    end

    assign o_rentry = r_rentry;

endmodule : bridge_fifo_ram
`default_nettype wire

// File: rtl/bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bridge_sync_fifo
// Description : Single-clock {address, data} FIFO with flags and sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_sync_fifo
    import bridge_fifo_pkg::*;
#(
    parameter int DSIZE     = c_def_dsize,
    parameter int AWIDTH    = c_def_awidth,
    parameter int ASIZE     = c_def_asize,
    parameter int AFULL_TH  = fifo_depth(ASIZE) - 2,
    parameter int AEMPTY_TH = c_def_aempty_th
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DSIZE-1:0]  wdata,
    input  logic [AWIDTH-1:0] waddr_in,
    input  logic              rd_en,
    output logic [DSIZE-1:0]  rdata,
    output logic [AWIDTH-1:0] address_out,
    output logic              rvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ASIZE:0]    count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int             c_depth   = fifo_depth(ASIZE);
    localparam int             c_ewidth  = entry_width(AWIDTH, DSIZE);
    localparam logic [ASIZE:0] c_one     = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] c_depth_v = c_one << ASIZE;

    logic [ASIZE:0]    r_wr_ptr;
    logic [ASIZE:0]    r_rd_ptr;
    logic [ASIZE:0]    r_count;
    logic              r_rvalid;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_full;
    logic              w_empty;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic [c_ewidth-1:0] w_rentry;

    assign w_full  = (r_count == c_depth_v);
    assign w_empty = (r_count == '0);

    // Flush swallows both requests and must not be reported as an error.
    assign w_rd_acc  = rd_en & ~w_empty & ~flush;
    assign w_wr_acc  = wr_en & (~w_full | w_rd_acc) & ~flush;
    assign w_ovf_set = wr_en & ~w_wr_acc & ~flush;
    assign w_udf_set = rd_en & ~w_rd_acc & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end
            r_count  <= r_count + {{ASIZE{1'b0}}, w_wr_acc} - {{ASIZE{1'b0}}, w_rd_acc};
            r_rvalid <= w_rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set | (r_overflow  & ~err_clr);
            r_underflow <= w_udf_set | (r_underflow & ~err_clr);
        end
    end

    bridge_fifo_ram #(
        .WIDTH (c_ewidth),
        .ABITS (ASIZE)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_wr_acc),
        .i_waddr  (r_wr_ptr[ASIZE-1:0]),
        .i_wentry ({waddr_in, wdata}),
        .i_re     (w_rd_acc),
        .i_raddr  (r_rd_ptr[ASIZE-1:0]),
        .o_rentry (w_rentry)
    );

    assign {address_out, rdata} = w_rentry;
    assign rvalid       = r_rvalid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (int'(r_count) >= AFULL_TH);
    assign almost_empty = (int'(r_count) <= AEMPTY_TH);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    initial assert (c_depth >= 2 && ASIZE <= 8);

endmodule : bridge_sync_fifo
`default_nettype wire

// File: tb/tb_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_bridge_sync_fifo
// Description : Directed self-checking bench for bridge_sync_fifo (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bridge_sync_fifo;

    logic        clk = 1'b0;
    logic        rst, flush, wr_en, rd_en, err_clr;
    logic [31:0] wdata, waddr_in, rdata, address_out;
    logic        rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0]  count;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    bridge_sync_fifo #(
        .DSIZE (32), .AWIDTH (32), .ASIZE (2), .AFULL_TH (2), .AEMPTY_TH (1)
    ) dut (
        .clk (clk), .rst (rst), .flush (flush), .wr_en (wr_en), .wdata (wdata),
        .waddr_in (waddr_in), .rd_en (rd_en), .rdata (rdata), .address_out (address_out),
        .rvalid (rvalid), .full (full), .empty (empty), .almost_full (almost_full),
        .almost_empty (almost_empty), .count (count), .overflow (overflow),
        .underflow (underflow), .err_clr (err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; wr_en = 0; rd_en = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        idle(); wdata = 0; waddr_in = 0;
        rst = 1; tick(); tick(); rst = 0;
        nvec++; if (count !== 3'd0)        begin nerr++; $display("FAIL reset_count got %0d exp 0", count); end
        nvec++; if ({empty, full, almost_empty, almost_full} !== 4'b1010)
            begin nerr++; $display("FAIL reset_flags got %b exp 1010", {empty, full, almost_empty, almost_full}); end
        nvec++; if ({rvalid, overflow, underflow} !== 3'b000)
            begin nerr++; $display("FAIL reset_status got %b exp 000", {rvalid, overflow, underflow}); end
        nvec++; if (rdata !== 32'h0 || address_out !== 32'h0)
            begin nerr++; $display("FAIL reset_rdata got %h/%h exp 0/0", address_out, rdata); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wdata = 32'h10 + i; waddr_in = 32'h100 + i; tick();
            nvec++; if (count !== 3'(i + 1)) begin nerr++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
        end
        wr_en = 0;
        nvec++; if ({full, almost_full, almost_empty} !== 3'b110)
            begin nerr++; $display("FAIL fill_flags got %b exp 110", {full, almost_full, almost_empty}); end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1; tick();
            nvec++; if (rvalid !== 1'b1 || rdata !== 32'h10 + i || address_out !== 32'h100 + i)
                begin nerr++; $display("FAIL drain[%0d] got v=%b %h/%h exp v=1 %h/%h", i, rvalid, address_out, rdata, 32'h100 + i, 32'h10 + i); end
        end
        rd_en = 0; tick();
        nvec++; if (rvalid !== 1'b0 || empty !== 1'b1 || rdata !== 32'h13)
            begin nerr++; $display("FAIL drain_end got v=%b e=%b d=%h exp v=0 e=1 d=13", rvalid, empty, rdata); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wdata = 32'h20 + i; waddr_in = 32'h200 + i; tick();
        end
        wr_en = 0;
        nvec++; if (count !== 3'd4 || overflow !== 1'b1)
            begin nerr++; $display("FAIL ovf_set got c=%0d o=%b exp c=4 o=1", count, overflow); end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1; tick();
            nvec++; if (rdata !== 32'h20 + i) begin nerr++; $display("FAIL ovf_read[%0d] got %h exp %h", i, rdata, 32'h20 + i); end
        end
        tick();
        nvec++; if (rvalid !== 1'b0 || rdata !== 32'h23 || underflow !== 1'b1)
            begin nerr++; $display("FAIL ovf_no5th got v=%b d=%h u=%b exp v=0 d=23 u=1", rvalid, rdata, underflow); end
        rd_en = 0; err_clr = 1; tick(); err_clr = 0;
        nvec++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin nerr++; $display("FAIL err_clr got o=%b u=%b exp 0/0", overflow, underflow); end
    endtask

    task automatic test_underflow();
        wr_en = 1; rd_en = 1; wdata = 32'h55; waddr_in = 32'h155; tick();
        wr_en = 0;
        nvec++; if (underflow !== 1'b1 || count !== 3'd1 || rvalid !== 1'b0)
            begin nerr++; $display("FAIL udf got u=%b c=%0d v=%b exp u=1 c=1 v=0", underflow, count, rvalid); end
        tick();
        nvec++; if (rvalid !== 1'b1 || rdata !== 32'h55 || address_out !== 32'h155 || count !== 3'd0)
            begin nerr++; $display("FAIL udf_read got v=%b %h/%h c=%0d exp v=1 155/55 c=0", rvalid, address_out, rdata, count); end
        rd_en = 0;
        // Error set and clear in the same cycle: set must win.
        rd_en = 1; err_clr = 1; tick(); rd_en = 0; err_clr = 0;
        nvec++; if (underflow !== 1'b1) begin nerr++; $display("FAIL set_wins got %b exp 1", underflow); end
        err_clr = 1; tick(); err_clr = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wdata = 32'h30 + i; waddr_in = 32'h300 + i; tick();
        end
        rd_en = 1; wdata = 32'h99; waddr_in = 32'h399; tick();
        wr_en = 0;
        nvec++; if (count !== 3'd4 || overflow !== 1'b0 || rvalid !== 1'b1 || rdata !== 32'h30)
            begin nerr++; $display("FAIL full_rw got c=%0d o=%b v=%b d=%h exp c=4 o=0 v=1 d=30", count, overflow, rvalid, rdata); end
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++; if (rdata !== ((i == 3) ? 32'h99 : 32'h31 + i))
                begin nerr++; $display("FAIL full_rw_read[%0d] got %h exp %h", i, rdata, (i == 3) ? 32'h99 : 32'h31 + i); end
        end
        rd_en = 0; tick();
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                wr_en = 1; wdata = 32'h40 + 3 * r + i; waddr_in = 32'h400 + 3 * r + i; tick();
                nvec++; if (almost_full !== (i + 1 >= 2) || almost_empty !== (i + 1 <= 1))
                    begin nerr++; $display("FAIL wrap_wflags[%0d.%0d] got af=%b ae=%b", r, i, almost_full, almost_empty); end
            end
            wr_en = 0;
            for (int i = 0; i < 3; i++) begin
                rd_en = 1; tick();
                nvec++; if (rdata !== 32'h40 + 3 * r + i || address_out !== 32'h400 + 3 * r + i)
                    begin nerr++; $display("FAIL wrap_read[%0d.%0d] got %h exp %h", r, i, rdata, 32'h40 + 3 * r + i); end
                nvec++; if (almost_full !== (2 - i >= 2) || almost_empty !== (2 - i <= 1))
                    begin nerr++; $display("FAIL wrap_rflags[%0d.%0d] got af=%b ae=%b", r, i, almost_full, almost_empty); end
            end
            rd_en = 0;
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wdata = 32'h60 + i; waddr_in = 32'h600 + i; tick();
        end
        flush = 1; rd_en = 1; tick(); flush = 0; rd_en = 0;
        nvec++; if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || rvalid !== 1'b0)
            begin nerr++; $display("FAIL flush got c=%0d e=%b o=%b u=%b v=%b exp 0 1 0 0 0", count, empty, overflow, underflow, rvalid); end
        for (int i = 0; i < 2; i++) begin
            wr_en = 1; wdata = 32'h70 + i; waddr_in = 32'h700 + i; tick();
        end
        wr_en = 0; rd_en = 1; tick();
        nvec++; if (rdata !== 32'h70 || count !== 3'd1)
            begin nerr++; $display("FAIL refill got d=%h c=%0d exp 70 1", rdata, count); end
        rst = 1; wr_en = 1; tick(); rst = 0; wr_en = 0; rd_en = 0;
        nvec++; if (count !== 3'd0 || rdata !== 32'h0 || address_out !== 32'h0 || rvalid !== 1'b0)
            begin nerr++; $display("FAIL rst_mid got c=%0d %h/%h v=%b exp 0 0/0 0", count, address_out, rdata, rvalid); end
        nvec++; if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000)
            begin nerr++; $display("FAIL rst_mid_flags got %b exp 101000", {empty, full, almost_empty, almost_full, overflow, underflow}); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_wrap();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_bridge_sync_fifo
`default_nettype wire
